// File: rtl/ibex_ex_seq_ctrl.sv
// Execute-stage sequencing controller: issues one instruction at a time to the ALU or
// mult/div unit, owns the shared intermediate register, and holds the result until ID takes it.
module ibex_ex_seq_ctrl #(
  parameter int MaxCycles = 40,
  parameter int CntW      = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  input  logic            issue_multdiv_i,
  output logic            issue_ready_o,
  input  logic            flush_i,
  output logic            unit_en_o,
  output logic            multdiv_sel_o,
  output logic            first_cycle_o,
  input  logic            unit_done_i,
  input  logic [1:0]      unit_imd_we_i,
  input  logic [67:0]     unit_imd_d_i,
  output logic [67:0]     imd_val_q_o,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic            busy_o,
  output logic [CntW-1:0] cycle_cnt_o,
  output logic            timeout_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_e;

  localparam logic [CntW-1:0] CntLast = CntW'(MaxCycles - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [67:0]     imd_q, imd_d;
  logic            md_q, md_d;
  logic            first_q, first_d;
  logic            timeout_q, timeout_d;
  logic            exec, hold, accept, watchdog;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (&v) ? v : v + {{(CntW-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      imd_q     <= '0;
      md_q      <= 1'b0;
      first_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      imd_q     <= imd_d;
      md_q      <= md_d;
      first_q   <= first_d;
      timeout_q <= timeout_d;
    end
  end

  // Handshake and status outputs; ready in EXEC lets a new op follow a finishing one with no bubble.
  always_comb begin
    exec           = (state_q == EXEC);
    hold           = (state_q == HOLD);
    issue_ready_o  = (state_q == IDLE) | (hold & result_ready_i) |
                     (exec & unit_done_i & result_ready_i);
    accept         = issue_valid_i & issue_ready_o & ~flush_i;
    watchdog       = exec & ~unit_done_i & (cnt_q == CntLast);
    result_valid_o = ~flush_i & (hold | (exec & unit_done_i));
    unit_en_o      = exec;
    busy_o         = (state_q != IDLE);
    multdiv_sel_o  = md_q;
    first_cycle_o  = first_q;
    cycle_cnt_o    = cnt_q;
    imd_val_q_o    = imd_q;
    timeout_o      = timeout_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    imd_d     = imd_q;
    md_d      = md_q;
    first_d   = 1'b0;
    timeout_d = timeout_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      imd_d   = '0;
    end else begin
      if (exec) begin
        cnt_d = sat_inc(cnt_q);
        if (unit_imd_we_i[0]) imd_d[33:0]  = unit_imd_d_i[33:0];
        if (unit_imd_we_i[1]) imd_d[67:34] = unit_imd_d_i[67:34];
      end
      case (state_q)
        IDLE: state_d = IDLE;
        EXEC: begin
          if (unit_done_i) begin
            state_d = result_ready_i ? IDLE : HOLD;
          end else if (watchdog) begin
            // A hung unit is abandoned: drop its partial state and never report a result.
            state_d   = IDLE;
            imd_d     = '0;
            timeout_d = 1'b1;
          end
        end
        HOLD:    if (result_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (accept) begin
        state_d = EXEC;
        md_d    = issue_multdiv_i;
        cnt_d   = '0;
        first_d = 1'b1;
      end
    end
  end

endmodule

// File: doc/ibex_ex_seq_ctrl.md
Name: ibex_ex_seq_ctrl

Overview:
- Sequencing controller for the execute stage.
- Accepts one instruction at a time from ID and drives the unit enable and the first-cycle strobe to the ALU and multiplier/divider.
- Owns the shared two-entry 34-bit intermediate-value register and holds the finished result until ID accepts it.
- Also enforces a cycle-count watchdog and handles pipeline flushes.

Parameters:
- MaxCycles, 40, number of EXEC cycles without unit_done_i before the watchdog fires (must be ≥ 2 and < 2**CntW).
- CntW, 6, width of the cycle counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- issue_valid_i  in  1  ID presents a new EX instruction.
- issue_multdiv_i  in  1  issued instruction targets mult/div (0 = ALU); sampled on accept.
- issue_ready_o  out  1  controller can accept an instruction this cycle.
- flush_i  in  1  kill the in-flight instruction.
- unit_en_o  out  1  dynamic enable to the selected unit.
- multdiv_sel_o  out  1  registered unit select (1 = mult/div).
- first_cycle_o  out  1  first EXEC cycle of the current instruction.
- unit_done_i  in  1  selected unit reports a valid result.
- unit_imd_we_i  in  2  intermediate-register write enables from the selected unit.
- unit_imd_d_i  in  68  write data: [33:0] = entry 0, [67:34] = entry 1.
- imd_val_q_o  out  68  intermediate-register contents, same packing.
- result_valid_o  out  1  result available to ID.
- result_ready_i  in  1  ID consumes the result.
- busy_o  out  1  state != IDLE.
- cycle_cnt_o  out  CntW  EXEC cycles spent on the current instruction.
- timeout_o  out  1  sticky watchdog error.

Behaviour:
- Reset (rst_i high, asynchronous): state = IDLE; imd registers, counter, multdiv_sel, first-cycle flag and timeout are all cleared to 0.
  - All outputs are derived from registered state, so during reset issue_ready_o = 1 and every other output = 0.
- States: IDLE, EXEC, HOLD.
- Accept condition: accept = issue_valid_i & issue_ready_o & ~flush_i.
- issue_ready_o is asserted when any of these holds:
  - state is IDLE;
  - state is HOLD and result_ready_i = 1;
  - state is EXEC and unit_done_i = 1 and result_ready_i = 1.
  - This allows back-to-back issue with no bubble.
- On accept:
  - next state = EXEC;
  - multdiv_sel is loaded from issue_multdiv_i;
  - the counter is cleared to 0;
  - the first-cycle flag is set, so first_cycle_o = 1 for exactly the next cycle.
- EXEC:
  - unit_en_o = 1.
  - Each imd entry i is written with its slice of unit_imd_d_i when unit_imd_we_i[i] = 1; writes outside EXEC are ignored.
  - The counter increments by 1 each cycle and saturates at all-ones.
- EXEC with unit_done_i = 1:
  - result_valid_o = 1 in the same cycle (combinational).
  - If result_ready_i = 1: go to IDLE, or back to EXEC on a fresh accept.
  - If result_ready_i = 0: go to HOLD.
- HOLD:
  - unit_en_o = 0 and result_valid_o = 1.
  - The imd registers and counter are frozen.
  - Leave HOLD when result_ready_i = 1 (to IDLE, or to EXEC on accept).
- Latency: a single-cycle ALU op accepted in cycle N has result_valid_o = 1 in cycle N+1.
- Watchdog: if in EXEC with cycle_cnt_o == MaxCycles-1 and unit_done_i = 0:
  - timeout_o is set and stays set until reset;
  - next state = IDLE and the imd registers are cleared;
  - no result_valid_o is produced.
- flush_i (any state): next state = IDLE, the imd registers and counter are cleared, and the first-cycle flag is cleared.
  - flush_i has priority over unit_done_i, accept and the watchdog.
  - result_valid_o is forced to 0 in a cycle where flush_i = 1.
- busy_o = (state != IDLE).
- Only one instruction is ever in flight; there is no queueing.

Test Plan:
- Reset, then single-cycle ALU op: issue_valid_i = 1, issue_multdiv_i = 0 in cycle 0 → cycle 1 has first_cycle_o = 1, unit_en_o = 1, multdiv_sel_o = 0; unit_done_i = 1 with result_ready_i = 1 → result_valid_o = 1 in cycle 1, and busy_o = 0 in cycle 2.
- 34-cycle divide with imd writes: issue with issue_multdiv_i = 1; we = 2'b11 with d = {34'h2_0000_0001, 34'h1_FFFF_FFFF} → the next cycle imd_val_q_o matches; done at cycle_cnt_o = 33 → result_valid_o = 1.
- Backpressure: done while result_ready_i = 0 for 3 cycles → HOLD, result_valid_o held at 1, unit_en_o = 0, imd frozen; ready = 1 together with a new issue → EXEC next cycle with first_cycle_o = 1 (no bubble).
- Flush mid-op: flush_i = 1 at cycle_cnt_o = 5, in the same cycle as unit_done_i = 1 → result_valid_o = 0 that cycle, IDLE next cycle, imd_val_q_o = 0, cycle_cnt_o = 0.
- Watchdog with MaxCycles = 40: unit_done_i held at 0 → timeout_o rises in the cycle after cycle_cnt_o = 39, state returns to IDLE; a later successful op leaves timeout_o = 1 until rst_i.
- Async reset mid-HOLD: rst_i pulsed between clock edges → outputs clear immediately, with issue_ready_o = 1 and result_valid_o = 0.
